// File: rtl/fir_poly_seq.sv
// Tap sequencer for the 120-tap polyphase FIR bank: one M-cycle tap sweep per accepted sample.
// Define FIR_POLY_SEQ_OVERRUN_EN to build the sticky dropped-sample (overrun) detector.
module fir_poly_seq #(
  parameter int M            = 20,
  parameter int M_LOG2       = 5,
  parameter int INPUT_WIDTH  = 12,
  parameter int TAP_WIDTH    = 16,
  parameter int OUTPUT_WIDTH = 35,
  parameter int DSP_LAT      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [INPUT_WIDTH-1:0]  din,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [M_LOG2-1:0]       cfg_addr,
  input  logic [TAP_WIDTH-1:0]    cfg_data,
  output logic [INPUT_WIDTH-1:0]  bank_din,
  output logic [M_LOG2-1:0]       tap_addr,
  output logic [TAP_WIDTH-1:0]    tap,
  input  logic [OUTPUT_WIDTH-1:0] bank_dout,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    dout_valid,
  output logic                    overrun,
  output logic                    busy
);

  typedef enum logic {IDLE, SWEEP} state_e;

  localparam logic [M_LOG2-1:0] LAST = M_LOG2'(M - 1);
  localparam int DL = DSP_LAT - 1;

  state_e                          state_q, state_d;
  logic        [M_LOG2-1:0]        tap_addr_q, tap_addr_d;
  logic signed [TAP_WIDTH-1:0]     tap_q, tap_d;
  logic signed [INPUT_WIDTH-1:0]   bank_din_q, bank_din_d;
  logic signed [OUTPUT_WIDTH-1:0]  dout_q, dout_d;
  logic                            dout_valid_q, dout_valid_d;
  logic        [DL-1:0]            dly_q, dly_d;
  logic signed [TAP_WIDTH-1:0]     coef_q [M];
  logic signed [TAP_WIDTH-1:0]     coef_d [M];
  logic                            accept, cfg_we, sweep_end;

  always_comb begin
    din_ready = (state_q == IDLE) || (tap_addr_q == LAST);
    cfg_ready = (state_q == IDLE) && !din_valid;
    accept    = din_valid && din_ready;
    cfg_we    = cfg_valid && cfg_ready && (cfg_addr < LAST + M_LOG2'(1));
    sweep_end = (state_q == SWEEP) && (tap_addr_q == LAST);
  end

  // p0: sweep control and tap address
  always_comb begin
    state_d    = state_q;
    tap_addr_d = tap_addr_q;
    bank_din_d = bank_din_q;
    if (accept) begin
      state_d    = SWEEP;
      tap_addr_d = '0;
      bank_din_d = din;
    end else if (state_q == SWEEP && tap_addr_q != LAST) begin
      tap_addr_d = tap_addr_q + M_LOG2'(1);
    end else begin
      state_d    = IDLE;
      tap_addr_d = LAST;
    end
  end

  // Coefficient read follows the next address; a same-cycle write is forwarded so it shows next cycle.
  always_comb begin
    coef_d = coef_q;
    if (cfg_we) coef_d[cfg_addr] = cfg_data;
    tap_d = coef_q[tap_addr_d];
    if (cfg_we && cfg_addr == tap_addr_d) tap_d = cfg_data;
  end

  // p1..pN: completion delay line, the last stage is dout_valid itself
  always_comb begin
    dly_d        = (dly_q << 1) | DL'(sweep_end);
    dout_valid_d = dly_q[DL-1];
    dout_d       = dly_q[DL-1] ? bank_dout : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tap_addr_q   <= LAST;
      tap_q        <= '0;
      bank_din_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dly_q        <= '0;
    end else begin
      state_q      <= state_d;
      tap_addr_q   <= tap_addr_d;
      tap_q        <= tap_d;
      bank_din_q   <= bank_din_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dly_q        <= dly_d;
    end
  end

  always_ff @(posedge clk) begin
    coef_q <= coef_d;
  end

`ifdef FIR_POLY_SEQ_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q || (din_valid && !din_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign tap_addr   = tap_addr_q;
  assign tap        = tap_q;
  assign bank_din   = bank_din_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == SWEEP);

endmodule

// File: tb/tb_fir_poly_seq.sv
// Scoreboard bench for fir_poly_seq: a cycle monitor predicts every output from the documented timing.
// The bank is stubbed so bank_dout registers into dout as the index of the cycle dout appears in.
module tb_fir_poly_seq;
  localparam int M = 20, ML = 5, IW = 12, TW = 16, OW = 35, DL = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          din_valid = 1'b0, cfg_valid = 1'b0;
  logic [IW-1:0] din = '0;
  logic [ML-1:0] cfg_addr = '0;
  logic [TW-1:0] cfg_data = '0;
  logic          din_ready, cfg_ready, dout_valid, overrun, busy;
  logic [IW-1:0] bank_din;
  logic [ML-1:0] tap_addr;
  logic [TW-1:0] tap;
  logic [OW-1:0] bank_dout, dout;

  fir_poly_seq #(.M(M), .M_LOG2(ML), .INPUT_WIDTH(IW), .TAP_WIDTH(TW),
                 .OUTPUT_WIDTH(OW), .DSP_LAT(DL)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .bank_din(bank_din), .tap_addr(tap_addr), .tap(tap), .bank_dout(bank_dout),
    .dout(dout), .dout_valid(dout_valid), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign bank_dout = OW'(cyc + 1);

`ifdef FIR_POLY_SEQ_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference state
  int            exp_ta;
  bit            exp_sweep, exp_ovr, coef_ok, tap_zero, mon_on;
  logic [IW-1:0] exp_bdin;
  logic [OW-1:0] exp_dout;
  logic [TW-1:0] coef_m [M];
  int            q[$];
  int            n_dv = 0;

  task automatic model_reset();
    exp_ta = M - 1; exp_sweep = 1'b0; exp_ovr = 1'b0;
    exp_bdin = '0; exp_dout = '0; q.delete(); tap_zero = 1'b1;
  endtask

  always @(negedge clk) begin
    bit rdy, acc, dv;
    if (mon_on) begin
      rdy = !exp_sweep || exp_ta == M - 1;
      chk("tap_addr", 64'(tap_addr), 64'(exp_ta));
      chk("busy", 64'(busy), 64'(exp_sweep));
      chk("din_ready", 64'(din_ready), 64'(rdy));
      chk("cfg_ready", 64'(cfg_ready), 64'(!exp_sweep && !din_valid));
      chk("overrun", 64'(overrun), 64'(exp_ovr));
      chk("bank_din", 64'(bank_din), 64'(exp_bdin));
      if (tap_zero) chk("tap_after_rst", 64'(tap), 64'(0));
      else if (coef_ok) chk("tap", 64'(tap), 64'(coef_m[exp_ta]));
      dv = q.size() > 0 && q[0] == cyc;
      chk("dout_valid", 64'(dout_valid), 64'(dv));
      if (dv) begin
        exp_dout = OW'(cyc);
        void'(q.pop_front());
        n_dv++;
      end
      chk("dout", 64'(dout), 64'(exp_dout));
      if (cfg_valid && !exp_sweep && !din_valid && int'(cfg_addr) < M)
        coef_m[cfg_addr] = cfg_data;
      if (rst) begin
        model_reset();
      end else begin
        acc = din_valid && rdy;
        if (OVR_EN && din_valid && !rdy) exp_ovr = 1'b1;
        if (acc) begin
          q.push_back(cyc + M + DL);
          exp_bdin = din; exp_ta = 0; exp_sweep = 1'b1;
        end else if (exp_sweep && exp_ta < M - 1) begin
          exp_ta++;
        end else begin
          exp_ta = M - 1; exp_sweep = 1'b0;
        end
        tap_zero = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [IW-1:0] s);
    din = s; din_valid = 1'b1; tick(); din_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_tap_addr", 64'(tap_addr), 64'(19));
    chk("rst_dout_valid", 64'(dout_valid), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_din_ready", 64'(din_ready), 64'(1));
    chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    tick();

    // Load coef[k] = k+1, plus one out-of-range write that must be ignored
    for (int k = 0; k < M; k++) begin
      cfg_valid = 1'b1; cfg_addr = ML'(k); cfg_data = TW'(k + 1); tick();
    end
    cfg_addr = ML'(25); cfg_data = 16'hDEAD; tick();
    cfg_valid = 1'b0; tick();
    coef_ok = 1'b1;
    tick();

    // Single sweep
    send(12'h123);
    @(negedge clk);
    chk("single_tap0", 64'(tap), 64'(1));
    repeat (30) tick();
    chk("single_bank_din", 64'(bank_din), 64'(12'h123));
    chk("single_dv_count", 64'(n_dv), 64'(1));
    chk("single_dout", 64'(dout), 64'(exp_dout));

    // Back-to-back: new sample offered exactly on each last sweep cycle
    for (int s = 1; s <= 3; s++) begin
      send(IW'(s));
      if (s < 3) repeat (M - 1) tick();
    end
    repeat (30) tick();
    chk("b2b_dv_count", 64'(n_dv), 64'(4));
    chk("b2b_overrun", 64'(overrun), 64'(0));

    // Priority: sample wins over a simultaneous write, which lands after the sweep
    cfg_valid = 1'b1; cfg_addr = '0; cfg_data = 16'h7FFF;
    send(12'h055);
    repeat (21) tick();
    cfg_valid = 1'b0;
    tick();
    send(12'h0AA);
    @(negedge clk);
    chk("prio_tap0", 64'(tap), 64'(16'h7FFF));
    repeat (30) tick();

    // Overrun: extra sample offered mid-sweep
    send(12'h007);
    repeat (4) tick();
    din = 12'h3FF; din_valid = 1'b1; tick(); din_valid = 1'b0;
    @(negedge clk);
    chk("ovr_set", 64'(overrun), 64'(OVR_EN));
    repeat (30) tick();
    chk("ovr_sticky", 64'(overrun), 64'(OVR_EN));
    chk("ovr_dv_count", 64'(n_dv), 64'(7));

    // Reset mid-sweep drops the in-flight result, keeps coefficients
    send(12'h009);
    repeat (9) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("midrst_tap_addr", 64'(tap_addr), 64'(19));
    chk("midrst_busy", 64'(busy), 64'(0));
    repeat (20) tick();
    chk("midrst_dv_count", 64'(n_dv), 64'(7));
    send(12'h811);
    repeat (30) tick();
    chk("final_dv_count", 64'(n_dv), 64'(8));
    chk("sb_empty", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
